// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-2 stream demultiplexer.
// Default widths and the port-select encoding.
package demux_pkg;

  localparam int N_DEF     = 32;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_sel_t;

endpackage

// File: rtl/demux_fifo.sv
// Per-port output buffer: circular storage with wrap-bit pointers.
// Head word is always presented; valid means non-empty.
module demux_fifo #(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [N-1:0] wdata,
  output logic         full,
  input  logic         pop,
  output logic         valid,
  output logic [N-1:0] data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [N-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         empty;

  // Extra MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid = !empty;
  assign data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '{default: '0};
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr <= wr_ptr + ONE;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + ONE;
      end
    end
  end

endmodule

// File: rtl/demux1to2_stream.sv
// 1-to-2 valid/ready stream demux with buffered outputs.
// Top holds push steering, in_ready select and delivery counters.
module demux1to2_stream
  import demux_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [N-1:0]     out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [N-1:0]     out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  port_sel_t sel;
  logic      full0;
  logic      full1;
  logic      push0;
  logic      push1;
  logic      pop0;
  logic      pop1;

  assign sel = port_sel_t'(in_sel);

  // Never depends on out*_ready: a full buffer refuses even while popping.
  assign in_ready = (sel == PORT1) ? !full1 : !full0;

  assign push0 = in_valid && in_ready && (sel == PORT0);
  assign push1 = in_valid && in_ready && (sel == PORT1);
  assign pop0  = out0_valid && out0_ready;
  assign pop1  = out1_valid && out1_ready;

  demux_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .wdata (in_data),
    .full  (full0),
    .pop   (pop0),
    .valid (out0_valid),
    .data  (out0_data)
  );

  demux_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .wdata (in_data),
    .full  (full1),
    .pop   (pop1),
    .valid (out1_valid),
    .data  (out1_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0 && (cnt0 != '1)) cnt0 <= cnt0 + C_ONE;
      if (pop1 && (cnt1 != '1)) cnt1 <= cnt1 + C_ONE;
    end
  end

endmodule

// File: tb/tb_demux1to2_stream.sv
// Scoreboard bench for demux1to2_stream (N=32, DEPTH=2, CNT_W=4).
// Model tracks occupancy, expected words and saturating counts.
module tb_demux1to2_stream;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sel;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out1_data;
  logic [3:0]  cnt0;
  logic [3:0]  cnt1;

  demux1to2_stream #(.N(32), .DEPTH(DEPTH), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  logic [31:0] got0[$];
  logic [31:0] got1[$];
  int occ0, occ1;
  int m_cnt0, m_cnt1;
  int n_pass, n_chk;

  // One clock: the model decides accept/pop from its own occupancy.
  task automatic step();
    bit acc0, acc1, p0, p1;
    #1;
    acc0 = in_valid && !in_sel && (occ0 < DEPTH);
    acc1 = in_valid &&  in_sel && (occ1 < DEPTH);
    p0 = out0_ready && (occ0 > 0);
    p1 = out1_ready && (occ1 > 0);
    if (acc0) exp0.push_back(in_data);
    if (acc1) exp1.push_back(in_data);
    if (p0) begin
      got0.push_back(out0_data);
      if (m_cnt0 != 15) m_cnt0++;
    end
    if (p1) begin
      got1.push_back(out1_data);
      if (m_cnt1 != 15) m_cnt1++;
    end
    occ0 = occ0 + int'(acc0) - int'(p0);
    occ1 = occ1 + int'(acc1) - int'(p1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    exp0.delete(); exp1.delete();
    got0.delete(); got1.delete();
    occ0 = 0; occ1 = 0;
    m_cnt0 = 0; m_cnt1 = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    model_clear();
    @(negedge clk); @(negedge clk);
    #1;
    n_chk++;
    if ({out0_valid, out1_valid} !== 2'b00)
      $display("FAIL reset_valid got=%b want=00", {out0_valid, out1_valid});
    else n_pass++;
    n_chk++;
    if ({out0_data, out1_data} !== 64'd0)
      $display("FAIL reset_data got=%h want=0", {out0_data, out1_data});
    else n_pass++;
    n_chk++;
    if ({cnt0, cnt1} !== 8'd0)
      $display("FAIL reset_cnt got=%h want=00", {cnt0, cnt1});
    else n_pass++;
    in_sel = 1'b1; #1;
    n_chk++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    else n_pass++;
    in_sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_route0();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hAAAA_AAAA;
    out0_ready = 1'b1; out1_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_chk++;
    if (out0_valid !== 1'b1 || out0_data !== 32'hAAAA_AAAA)
      $display("FAIL route0_out got=%b/%h want=1/aaaaaaaa", out0_valid, out0_data);
    else n_pass++;
    n_chk++;
    if (out1_valid !== 1'b0)
      $display("FAIL route0_other got=%b want=0", out1_valid);
    else n_pass++;
    step();
    n_chk++;
    if (cnt0 !== 4'(m_cnt0))
      $display("FAIL route0_cnt0 got=%0d want=%0d", cnt0, m_cnt0);
    else n_pass++;
    n_chk++;
    if (got0.size() != 1 || exp0.size() != 1)
      $display("FAIL route0_count got=%0d want=%0d", got0.size(), exp0.size());
    else begin
      n_pass++;
      n_chk++;
      if (got0[0] !== exp0[0])
        $display("FAIL route0_word got=%h want=%h", got0[0], exp0[0]);
      else n_pass++;
    end
    got0.delete(); exp0.delete();
  endtask

  task automatic test_route1();
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h5555_5555;
    out0_ready = 1'b0; out1_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_chk++;
    if (out1_valid !== 1'b1 || out1_data !== 32'h5555_5555)
      $display("FAIL route1_out got=%b/%h want=1/55555555", out1_valid, out1_data);
    else n_pass++;
    n_chk++;
    if (out0_valid !== 1'b0)
      $display("FAIL route1_port0 got=%b want=0", out0_valid);
    else n_pass++;
    step();
    n_chk++;
    if (cnt1 !== 4'(m_cnt1) || cnt0 !== 4'(m_cnt0))
      $display("FAIL route1_cnt got=%0d/%0d want=%0d/%0d", cnt0, cnt1, m_cnt0, m_cnt1);
    else n_pass++;
    while (got1.size() > 0 && exp1.size() > 0) begin
      n_chk++;
      if (got1[0] !== exp1[0])
        $display("FAIL route1_word got=%h want=%h", got1[0], exp1[0]);
      else n_pass++;
      void'(got1.pop_front()); void'(exp1.pop_front());
    end
  endtask

  task automatic test_backpressure();
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0;
    in_data = 32'h1234_5678; step();
    in_data = 32'h8765_4321; step();
    in_valid = 1'b0; #1;
    n_chk++;
    if (in_ready !== 1'b0)
      $display("FAIL bp_ready_sel0 got=%b want=0", in_ready);
    else n_pass++;
    in_sel = 1'b1; #1;
    n_chk++;
    if (in_ready !== 1'b1)
      $display("FAIL bp_ready_sel1 got=%b want=1", in_ready);
    else n_pass++;
    step();
    n_chk++;
    if (out0_valid !== 1'b1 || out0_data !== 32'h1234_5678)
      $display("FAIL bp_hold got=%b/%h want=1/12345678", out0_valid, out0_data);
    else n_pass++;
    out0_ready = 1'b1;
    step(); step();
    n_chk++;
    if (cnt0 !== 4'(m_cnt0) || out0_valid !== 1'b0)
      $display("FAIL bp_cnt0 got=%0d/%b want=%0d/0", cnt0, out0_valid, m_cnt0);
    else n_pass++;
    n_chk++;
    if (got0.size() != exp0.size())
      $display("FAIL bp_count got=%0d want=%0d", got0.size(), exp0.size());
    else n_pass++;
    while (got0.size() > 0 && exp0.size() > 0) begin
      n_chk++;
      if (got0[0] !== exp0[0])
        $display("FAIL bp_order got=%h want=%h", got0[0], exp0[0]);
      else n_pass++;
      void'(got0.pop_front()); void'(exp0.pop_front());
    end
  endtask

  task automatic test_interleave();
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0;
    in_data = 32'h0000_0A01; step();
    in_data = 32'h0000_0A02; step();
    in_sel = 1'b1; in_data = 32'h0000_0B03; out0_ready = 1'b1; #1;
    n_chk++;
    if (in_ready !== 1'b1)
      $display("FAIL il_other_ready got=%b want=1", in_ready);
    else n_pass++;
    step();
    n_chk++;
    if (out0_valid !== 1'b1 || out0_data !== 32'h0000_0A02)
      $display("FAIL il_port0 got=%b/%h want=1/00000a02", out0_valid, out0_data);
    else n_pass++;
    n_chk++;
    if (out1_valid !== 1'b1 || out1_data !== 32'h0000_0B03)
      $display("FAIL il_port1 got=%b/%h want=1/00000b03", out1_valid, out1_data);
    else n_pass++;
    in_sel = 1'b0; in_data = 32'h0000_0A04;
    step();
    n_chk++;
    if (out0_valid !== 1'b1 || out0_data !== 32'h0000_0A04)
      $display("FAIL il_pushpop got=%b/%h want=1/00000a04", out0_valid, out0_data);
    else n_pass++;
    out0_ready = 1'b0; in_data = 32'h0000_0A05;
    step();
    in_data = 32'h0000_0A06; out0_ready = 1'b1; #1;
    n_chk++;
    if (in_ready !== 1'b0)
      $display("FAIL il_full_refuse got=%b want=0", in_ready);
    else n_pass++;
    step();
    in_valid = 1'b0; out1_ready = 1'b1;
    step(); step(); step();
    n_chk++;
    if (got0.size() != exp0.size() || got1.size() != exp1.size())
      $display("FAIL il_count got=%0d/%0d want=%0d/%0d",
               got0.size(), got1.size(), exp0.size(), exp1.size());
    else n_pass++;
    while (got0.size() > 0 && exp0.size() > 0) begin
      n_chk++;
      if (got0[0] !== exp0[0])
        $display("FAIL il_word0 got=%h want=%h", got0[0], exp0[0]);
      else n_pass++;
      void'(got0.pop_front()); void'(exp0.pop_front());
    end
    while (got1.size() > 0 && exp1.size() > 0) begin
      n_chk++;
      if (got1[0] !== exp1[0])
        $display("FAIL il_word1 got=%h want=%h", got1[0], exp1[0]);
      else n_pass++;
      void'(got1.pop_front()); void'(exp1.pop_front());
    end
  endtask

  task automatic test_reset_mid();
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 1'b0; in_data = 32'hDEAD_0000; step();
    in_sel = 1'b1; in_data = 32'hDEAD_0001; step();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    model_clear();
    n_chk++;
    if ({out0_valid, out1_valid} !== 2'b00 || {cnt0, cnt1} !== 8'd0)
      $display("FAIL rst_mid got=%b/%h want=00/00",
               {out0_valid, out1_valid}, {cnt0, cnt1});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if ({out0_valid, out1_valid} !== 2'b00)
        $display("FAIL rst_stale got=%b want=00", {out0_valid, out1_valid});
      else n_pass++;
    end
    out0_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hC0DE_0001;
    step();
    in_valid = 1'b0;
    n_chk++;
    if (out0_valid !== 1'b1 || out0_data !== 32'hC0DE_0001)
      $display("FAIL rst_first got=%b/%h want=1/c0de0001", out0_valid, out0_data);
    else n_pass++;
    out0_ready = 1'b1;
    step();
    while (got0.size() > 0 && exp0.size() > 0) begin
      n_chk++;
      if (got0[0] !== exp0[0])
        $display("FAIL rst_word got=%h want=%h", got0[0], exp0[0]);
      else n_pass++;
      void'(got0.pop_front()); void'(exp0.pop_front());
    end
  endtask

  task automatic test_saturation();
    out0_ready = 1'b0; out1_ready = 1'b1;
    in_sel = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'h5A00_0000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    n_chk++;
    if (cnt1 !== 4'd15 || m_cnt1 != 15)
      $display("FAIL sat_cnt1 got=%0d want=15 (model %0d)", cnt1, m_cnt1);
    else n_pass++;
    n_chk++;
    if (got1.size() != 20 || exp1.size() != 20)
      $display("FAIL sat_count got=%0d want=%0d", got1.size(), exp1.size());
    else n_pass++;
    while (got1.size() > 0 && exp1.size() > 0) begin
      n_chk++;
      if (got1[0] !== exp1[0])
        $display("FAIL sat_word got=%h want=%h", got1[0], exp1[0]);
      else n_pass++;
      void'(got1.pop_front()); void'(exp1.pop_front());
    end
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    test_reset();
    test_route0();
    test_route1();
    test_backpressure();
    test_interleave();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
